// File: rtl/serial_logic_engine_pkg.sv
// -----------------------------------------------------------------------------
// serial_logic_engine_pkg
// Shared definitions for the bit-serial logic engine: FSM state encoding,
// named truth-table codes for common functions, and the per-bit truth-table
// lookup used by logicalunit.
// -----------------------------------------------------------------------------
package serial_logic_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Truth-table codes: result bit = func[{a,b}]
  localparam logic [3:0] FUNC_AND    = 4'h8;
  localparam logic [3:0] FUNC_OR     = 4'hE;
  localparam logic [3:0] FUNC_XOR    = 4'h6;
  localparam logic [3:0] FUNC_NAND   = 4'h7;
  localparam logic [3:0] FUNC_PASS_A = 4'hC;
  localparam logic [3:0] FUNC_PASS_B = 4'hA;

  // Select one truth-table entry using the operand bit pair as the index.
  function automatic logic lu_eval(input logic [3:0] f, input logic a, input logic b);
    return f[{a, b}];
  endfunction

endpackage

// File: rtl/serial_logic_engine_logicalunit.sv
// -----------------------------------------------------------------------------
// logicalunit
// Single-bit programmable logic cell: out = func[{a,b}].
// Ports:
//   a, b  - operand bits
//   func  - 4-bit truth table
//   out   - selected truth-table entry
// -----------------------------------------------------------------------------
module logicalunit
  import serial_logic_engine_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [3:0] func,
  output logic       out
);

  assign out = lu_eval(func, a, b);

endmodule

// File: rtl/serial_logic_engine.sv
// -----------------------------------------------------------------------------
// serial_logic_engine
// Bit-serial front end for logicalunit. Accepts two WIDTH-bit operands and a
// truth-table code, evaluates one bit pair per cycle LSB-first, and presents
// the assembled result on an output valid/ready handshake.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - operation handshake (op_a, op_b, func)
//   out_valid / out_ready- result handshake (result)
//   busy                 - high while shifting or holding a result
// -----------------------------------------------------------------------------
module serial_logic_engine
  import serial_logic_engine_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] a_sr_q,   a_sr_d;
  logic [WIDTH-1:0] b_sr_q,   b_sr_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic [3:0]       func_q,   func_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q,      busy_d;
  logic             lu_out_s;
  logic [WIDTH-1:0] res_shift_s;

  // Per-bit evaluation on the current LSBs of the operand shift registers.
  logicalunit u_lu (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .func (func_q),
    .out  (lu_out_s)
  );

  // New bit enters at the MSB so the first-evaluated bit ends up at bit 0;
  // written as a loop so WIDTH==1 needs no special-case slice.
  always_comb begin
    res_shift_s = '0;
    res_shift_s[WIDTH-1] = lu_out_s;
    for (int i = 0; i < WIDTH - 1; i++) begin
      res_shift_s[i] = res_q[i+1];
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    func_d  = func_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_sr_d  = op_a;
          b_sr_d  = op_b;
          func_d  = func;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        res_d  = res_shift_s;
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs are decoded from the next state so they leave a flop.
  always_comb begin
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      res_q       <= '0;
      func_q      <= 4'h0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      res_q       <= res_d;
      func_q      <= func_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = res_q;

endmodule

// File: tb/tb_serial_logic_engine.sv
module tb_serial_logic_engine;
  import serial_logic_engine_pkg::*;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       func;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  int checks = 0;
  int passed = 0;

  serial_logic_engine #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .func      (func),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an op at a negedge, let it be taken at the next posedge, then
  // drop in_valid and return at the following negedge.
  task automatic send_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    func     = f;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  // Counts posedges from the current negedge until out_valid is seen; 40 means timeout.
  task automatic wait_out_valid(output int cycles);
    cycles = 0;
    while (cycles < 40) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_a      = 8'h00;
    op_b      = 8'h00;
    func      = 4'h0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, result} !== {1'b1, 1'b0, 1'b0, 8'h00})
      $display("FAIL reset_outputs: got rdy/vld/busy/res=%b%b%b/%h want 100/00",
               in_ready, out_valid, busy, result);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100)
      $display("FAIL post_reset_idle: got %b want 100", {in_ready, out_valid, busy});
    else passed++;
  endtask

  task automatic test_and_latency;
    int cyc;
    send_op(8'hF0, 8'hCC, FUNC_AND);
    checks++;
    if ({in_ready, busy} !== 2'b01)
      $display("FAIL shift_flags: got rdy/busy=%b want 01", {in_ready, busy});
    else passed++;
    wait_out_valid(cyc);
    checks++;
    if (cyc !== 8) $display("FAIL latency: got %0d edges want 8", cyc);
    else passed++;
    checks++;
    if (result !== 8'hC0) $display("FAIL and_result: got %h want c0", result);
    else passed++;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL done_in_ready: got %b want 0", in_ready);
    else passed++;
    @(negedge clk); // handshake at the intervening posedge
    checks++;
    if ({in_ready, out_valid, busy, result} !== {1'b1, 1'b0, 1'b0, 8'hC0})
      $display("FAIL after_handshake: got rdy/vld/busy/res=%b%b%b/%h want 100/c0",
               in_ready, out_valid, busy, result);
    else passed++;
  endtask

  task automatic test_funcs;
    logic [3:0] fv [8] = '{4'h8, 4'hE, 4'h6, 4'h7, 4'hC, 4'hA, 4'h0, 4'hF};
    logic [7:0] ev [8] = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'hF0, 8'hCC, 8'h00, 8'hFF};
    int cyc;
    for (int i = 0; i < 8; i++) begin
      send_op(8'hF0, 8'hCC, fv[i]);
      wait_out_valid(cyc);
      checks++;
      if (cyc !== 8 || result !== ev[i])
        $display("FAIL func_%h: got res=%h after %0d edges want %h after 8", fv[i], result, cyc, ev[i]);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    out_ready = 1'b0;
    send_op(8'hF0, 8'hCC, FUNC_AND);
    wait_out_valid(cyc);
    // Different op offered while the result is stalled.
    in_valid = 1'b1;
    op_a     = 8'hFF;
    op_b     = 8'h00;
    func     = FUNC_PASS_A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 8'hC0})
        $display("FAIL stall_%0d: got vld/rdy/res=%b%b/%h want 10/c0", i, out_valid, in_ready, result);
      else passed++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL stall_release: got vld/rdy=%b want 01", {out_valid, in_ready});
    else passed++;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) $display("FAIL pending_accept: got busy=%b want 1", busy);
    else passed++;
    wait_out_valid(cyc);
    checks++;
    if (cyc !== 8 || result !== 8'hFF)
      $display("FAIL pending_result: got res=%h after %0d edges want ff after 8", result, cyc);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_input_change;
    int cyc;
    send_op(8'hF0, 8'hCC, FUNC_AND);
    in_valid = 1'b1;
    op_a     = 8'h00;
    func     = 4'h0;
    wait_out_valid(cyc);
    in_valid = 1'b0;
    checks++;
    if (cyc !== 8 || result !== 8'hC0)
      $display("FAIL input_change: got res=%h after %0d edges want c0 after 8", result, cyc);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc;
    in_valid = 1'b1;
    op_a     = 8'hF0;
    op_b     = 8'hCC;
    func     = FUNC_AND;
    @(posedge clk);
    #1 func = FUNC_OR;
    @(negedge clk);
    wait_out_valid(cyc);
    checks++;
    if (cyc !== 8 || result !== 8'hC0)
      $display("FAIL b2b_first: got res=%h after %0d edges want c0 after 8", result, cyc);
    else passed++;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) $display("FAIL b2b_idle: got in_ready=%b want 1", in_ready);
    else passed++;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    wait_out_valid(cyc);
    checks++;
    if (cyc !== 8 || result !== 8'hFC)
      $display("FAIL b2b_second: got res=%h after %0d edges want fc after 8", result, cyc);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_shift;
    int cyc;
    send_op(8'hF0, 8'hCC, FUNC_AND);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, busy, result} !== {1'b0, 1'b1, 1'b0, 8'h00})
      $display("FAIL async_reset: got vld/rdy/busy/res=%b%b%b/%h want 010/00",
               out_valid, in_ready, busy, result);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if ({out_valid, busy} !== 2'b00)
      $display("FAIL no_partial_valid: got vld/busy=%b want 00", {out_valid, busy});
    else passed++;
    send_op(8'hAA, 8'h55, FUNC_XOR);
    wait_out_valid(cyc);
    checks++;
    if (cyc !== 8 || result !== 8'hFF)
      $display("FAIL fresh_after_reset: got res=%h after %0d edges want ff after 8", result, cyc);
    else passed++;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_and_latency;
    test_funcs;
    test_backpressure;
    test_input_change;
    test_back_to_back;
    test_reset_mid_shift;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
